snoop_bus_ctrl: RTL and testbench

SNOOP_BUS_CTRL -- requirements
Module: snoop_bus_ctrl

---
 rtl/snoop_bus_ctrl_pkg.sv | 32 +++
 rtl/snoop_bus_ctrl_rr_arbiter.sv | 33 +++
 rtl/snoop_bus_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_snoop_bus_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snoop_bus_ctrl_pkg.sv
// Shared types and constants for the snooping bus controller: bus operations,
// fill-source encodings, MSI block-state codes and the controller FSM states.
package common;

   typedef enum logic [1:0] {
      OP_RD  = 2'd0,
      OP_WR  = 2'd1,
      OP_INV = 2'd2
   } bus_op_t;

   localparam logic [1:0] SOURCE_DMEM       = 2'd0;
   localparam logic [1:0] SOURCE_OTHER_PROC = 2'd1;

   localparam logic [1:0] BLOCK_STATE_I = 2'b00;
   localparam logic [1:0] BLOCK_STATE_S = 2'b01;
   localparam logic [1:0] BLOCK_STATE_M = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SNOOP,
      ST_XFER,
      ST_MEM_WAIT,
      ST_INV,
      ST_DONE
   } bus_state_t;

   // Encoding 11 is not a legal MSI state and counts as "no copy held".
   function automatic logic holds_copy(input logic [1:0] st);
      return (st == BLOCK_STATE_S) || (st == BLOCK_STATE_M);
   endfunction

endpackage

// File: rtl/snoop_bus_ctrl_rr_arbiter.sv
// Round-robin picker: first requester found scanning upward from ptr_i, with wrap.
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic [N-1:0]         req_i,
   input  logic [$clog2(N)-1:0] ptr_i,
   output logic [N-1:0]         gnt_o,
   output logic [$clog2(N)-1:0] idx_o,
   output logic                 valid_o
);

   localparam int IW = $clog2(N);

   logic [IW:0] cand;

   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      cand    = '0;
      for (int k = 0; k < N; k++) begin
         // ptr_i < N and k < N, so a single subtraction wraps the candidate.
         cand = {1'b0, ptr_i} + (IW+1)'(k);
         if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
         if (!valid_o && req_i[cand[IW-1:0]]) begin
            valid_o              = 1'b1;
            idx_o                = cand[IW-1:0];
            gnt_o[cand[IW-1:0]]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/snoop_bus_ctrl.sv
// Snooping bus controller: round-robin arbitration of CPU misses/upgrades, one
// snoop cycle, then cache-to-cache transfer, memory fill or invalidate.
module snoop_bus_ctrl
   import common::*;
#(
   parameter int NUM_CPU = 2,
   parameter int ADDR_W  = 13,
   parameter int MEM_LAT = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_CPU-1:0]          req_rd,
   input  logic [NUM_CPU-1:0]          req_wr,
   input  logic [NUM_CPU-1:0]          req_inv,
   input  logic [NUM_CPU*ADDR_W-1:0]   req_addr,
   input  logic [NUM_CPU-1:0]          snoop_hit,
   input  logic [2*NUM_CPU-1:0]        snoop_state,
   output logic [NUM_CPU-1:0]          grant,
   output logic                        snoop_valid,
   output logic [ADDR_W-1:0]           snoop_addr,
   output logic [1:0]                  bus_op,
   output logic [NUM_CPU-1:0]          inv,
   output logic [NUM_CPU-1:0]          wb_req,
   output logic [1:0]                  datasel,
   output logic [$clog2(NUM_CPU)-1:0]  src_id,
   output logic [NUM_CPU-1:0]          done,
   output logic                        busy
);

   localparam int IW = $clog2(NUM_CPU);
   localparam logic [NUM_CPU-1:0] ONE = NUM_CPU'(1);

   bus_state_t          state_q, state_d;
   bus_op_t             op_q, op_d;
   logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]       owner_q, owner_d;
   logic [IW-1:0]       src_q, src_d;
   logic                src_m_q, src_m_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [NUM_CPU-1:0]  hit_q, hit_d;
   logic [3:0]          cnt_q, cnt_d;

   logic [NUM_CPU-1:0]  pending, arb_gnt, hit_vec, m_vec;
   logic [IW-1:0]       arb_idx, first_hit, first_m;
   logic                arb_valid;

   assign pending = req_rd | req_wr | req_inv;

   rr_arbiter #(.N(NUM_CPU)) u_arb (
      .req_i   (pending),
      .ptr_i   (rr_ptr_q),
      .gnt_o   (arb_gnt),
      .idx_o   (arb_idx),
      .valid_o (arb_valid)
   );

   // The owner's own snoop response is masked out of both vectors.
   always_comb begin
      hit_vec   = '0;
      m_vec     = '0;
      first_hit = '0;
      first_m   = '0;
      for (int i = 0; i < NUM_CPU; i++) begin
         if (snoop_hit[i] && (IW'(i) != owner_q)) begin
            hit_vec[i] = holds_copy(snoop_state[2*i +: 2]);
            m_vec[i]   = (snoop_state[2*i +: 2] == BLOCK_STATE_M);
         end
      end
      for (int i = NUM_CPU-1; i >= 0; i--) begin
         if (hit_vec[i]) first_hit = IW'(i);
         if (m_vec[i])   first_m   = IW'(i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_RD;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         src_q    <= '0;
         src_m_q  <= 1'b0;
         addr_q   <= '0;
         hit_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         src_q    <= src_d;
         src_m_q  <= src_m_d;
         addr_q   <= addr_d;
         hit_q    <= hit_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      src_d    = src_q;
      src_m_d  = src_m_q;
      addr_d   = addr_q;
      hit_d    = hit_q;
      cnt_d    = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (arb_valid) begin
               owner_d = arb_idx;
               addr_d  = req_addr[arb_idx*ADDR_W +: ADDR_W];
               if (req_rd[arb_idx])      op_d = OP_RD;
               else if (req_wr[arb_idx]) op_d = OP_WR;
               else                      op_d = OP_INV;
               state_d = ST_SNOOP;
            end
         end
         ST_SNOOP: begin
            hit_d   = hit_vec;
            cnt_d   = '0;
            src_d   = '0;
            src_m_d = 1'b0;
            case (op_q)
               OP_RD: begin
                  if (|hit_vec) begin
                     src_d   = first_hit;
                     src_m_d = m_vec[first_hit];
                     state_d = ST_XFER;
                  end else begin
                     state_d = ST_MEM_WAIT;
                  end
               end
               OP_WR: begin
                  if (|m_vec) begin
                     src_d   = first_m;
                     src_m_d = 1'b1;
                     state_d = ST_XFER;
                  end else begin
                     state_d = ST_MEM_WAIT;
                  end
               end
               default: state_d = ST_INV;
            endcase
         end
         ST_XFER: state_d = ST_DONE;
         ST_MEM_WAIT: begin
            if (cnt_q == 4'(MEM_LAT-1)) state_d = ST_DONE;
            else                        cnt_d   = cnt_q + 4'd1;
         end
         ST_INV: state_d = ST_DONE;
         ST_DONE: begin
            rr_ptr_d = (owner_q == IW'(NUM_CPU-1)) ? '0 : owner_q + 1'b1;
            cnt_d    = '0;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // All outputs decode registered state only.
   always_comb begin
      grant       = '0;
      snoop_valid = 1'b0;
      inv         = '0;
      wb_req      = '0;
      datasel     = SOURCE_DMEM;
      src_id      = '0;
      done        = '0;
      busy        = (state_q != ST_IDLE);
      snoop_addr  = addr_q;
      bus_op      = op_q;
      if (state_q != ST_IDLE) grant = ONE << owner_q;
      case (state_q)
         ST_SNOOP: snoop_valid = 1'b1;
         ST_XFER: begin
            datasel = SOURCE_OTHER_PROC;
            src_id  = src_q;
            if (op_q == OP_WR)              inv    = hit_q;
            if (op_q == OP_RD && src_m_q)   wb_req = ONE << src_q;
         end
         ST_MEM_WAIT: begin
            if (op_q == OP_WR && cnt_q == 4'd0) inv = hit_q;
         end
         ST_INV:  inv  = hit_q;
         ST_DONE: done = ONE << owner_q;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// Directed bench for snoop_bus_ctrl (4 CPUs, MEM_LAT 4): stimulus pushes expected
// transaction records; a forked monitor rebuilds each transaction and compares at done.
module tb_snoop_bus_ctrl;
   import common::*;

   localparam int N   = 4;
   localparam int AW  = 13;
   localparam int LAT = 4;

   logic              clk, rst_n;
   logic [N-1:0]      req_rd, req_wr, req_inv, snoop_hit;
   logic [N*AW-1:0]   req_addr;
   logic [2*N-1:0]    snoop_state;
   logic [N-1:0]      grant, inv, wb_req, done;
   logic              snoop_valid, busy;
   logic [AW-1:0]     snoop_addr;
   logic [1:0]        bus_op, datasel;
   logic [1:0]        src_id;

   snoop_bus_ctrl #(.NUM_CPU(N), .ADDR_W(AW), .MEM_LAT(LAT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_rd      (req_rd),
      .req_wr      (req_wr),
      .req_inv     (req_inv),
      .req_addr    (req_addr),
      .snoop_hit   (snoop_hit),
      .snoop_state (snoop_state),
      .grant       (grant),
      .snoop_valid (snoop_valid),
      .snoop_addr  (snoop_addr),
      .bus_op      (bus_op),
      .inv         (inv),
      .wb_req      (wb_req),
      .datasel     (datasel),
      .src_id      (src_id),
      .done        (done),
      .busy        (busy)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic [3:0]  done_v;
      logic [3:0]  grant_v;
      logic [12:0] addr;
      logic [1:0]  op;
      logic [3:0]  inv_v;
      logic [3:0]  inv_n;
      logic [3:0]  wb_v;
      logic [3:0]  wb_n;
      logic [3:0]  xfer_n;
      logic [1:0]  src;
      logic [4:0]  lat;
   } txn_t;
   localparam int TW = $bits(txn_t);

   logic [TW-1:0] exp_q[$];
   int n_checks;
   int n_fail;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
      end
   endtask

   function automatic txn_t mk(input logic [3:0] done_v, input logic [12:0] addr,
                               input logic [1:0] op, input logic [3:0] inv_v,
                               input logic [3:0] inv_n, input logic [3:0] wb_v,
                               input logic [3:0] wb_n, input logic [3:0] xfer_n,
                               input logic [1:0] src, input logic [4:0] lat);
      txn_t t;
      t.done_v = done_v; t.grant_v = done_v; t.addr = addr; t.op = op;
      t.inv_v = inv_v; t.inv_n = inv_n; t.wb_v = wb_v; t.wb_n = wb_n;
      t.xfer_n = xfer_n; t.src = src; t.lat = lat;
      return t;
   endfunction

   task automatic push(input txn_t t);
      exp_q.push_back(TW'(t));
   endtask

   // lat counts the IDLE pick cycle plus every busy cycle up to and including DONE.
   task automatic monitor();
      txn_t a, e;
      int   lat;
      a = '0; lat = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            a = '0; lat = 0;
         end else begin
            if (busy) begin
               lat++;
               a.grant_v = a.grant_v | grant;
               if (|inv)    begin a.inv_v = a.inv_v | inv;   a.inv_n = a.inv_n + 4'd1; end
               if (|wb_req) begin a.wb_v = a.wb_v | wb_req;  a.wb_n = a.wb_n + 4'd1;  end
               if (datasel == SOURCE_OTHER_PROC) begin a.xfer_n = a.xfer_n + 4'd1; a.src = src_id; end
            end
            if (|done) begin
               a.done_v = done; a.addr = snoop_addr; a.op = bus_op; a.lat = 5'(lat + 1);
               if (exp_q.size() == 0) begin
                  chk("unexpected_done", 32'(done), 32'd0);
               end else begin
                  e = txn_t'(exp_q.pop_front());
                  chk("done",     32'(a.done_v),  32'(e.done_v));
                  chk("grant",    32'(a.grant_v), 32'(e.grant_v));
                  chk("addr",     32'(a.addr),    32'(e.addr));
                  chk("bus_op",   32'(a.op),      32'(e.op));
                  chk("inv_mask", 32'(a.inv_v),   32'(e.inv_v));
                  chk("inv_cyc",  32'(a.inv_n),   32'(e.inv_n));
                  chk("wb_mask",  32'(a.wb_v),    32'(e.wb_v));
                  chk("wb_cyc",   32'(a.wb_n),    32'(e.wb_n));
                  chk("xfer_cyc", 32'(a.xfer_n),  32'(e.xfer_n));
                  chk("src_id",   32'(a.src),     32'(e.src));
                  chk("latency",  32'(a.lat),     32'(e.lat));
               end
               a = '0; lat = 0;
            end
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic clear_inputs();
      req_rd = '0; req_wr = '0; req_inv = '0; req_addr = '0;
      snoop_hit = '0; snoop_state = '0;
   endtask

   task automatic set_snoop(input int cpu, input logic [1:0] st);
      snoop_hit[cpu]         = 1'b1;
      snoop_state[2*cpu +: 2] = st;
   endtask

   task automatic issue(input int cpu, input logic rd, input logic wr, input logic iv,
                        input logic [12:0] addr);
      req_addr[cpu*AW +: AW] = addr;
      req_rd[cpu]  = rd;
      req_wr[cpu]  = wr;
      req_inv[cpu] = iv;
   endtask

   // Drops each CPU's request in its DONE cycle; optionally lets CPU0 keep its
   // request once to re-request immediately after being served.
   task automatic run_until_idle(input int budget, input bit reissue0);
      int n;
      bit again;
      n = 0; again = reissue0;
      while (n < budget) begin
         @(negedge clk);
         n++;
         for (int i = 0; i < N; i++) begin
            if (done[i]) begin
               if (i == 0 && again) again = 1'b0;
               else begin req_rd[i] = 1'b0; req_wr[i] = 1'b0; req_inv[i] = 1'b0; end
            end
         end
         if (req_rd == '0 && req_wr == '0 && req_inv == '0 && !busy) break;
      end
      chk("idle_within_budget", 32'(n < budget), 32'd1);
      snoop_hit = '0; snoop_state = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_grant"},   32'(grant),       32'd0);
      chk({tag, "_busy"},    32'(busy),        32'd0);
      chk({tag, "_done"},    32'(done),        32'd0);
      chk({tag, "_svalid"},  32'(snoop_valid), 32'd0);
      chk({tag, "_saddr"},   32'(snoop_addr),  32'd0);
      chk({tag, "_bus_op"},  32'(bus_op),      32'd0);
      chk({tag, "_inv"},     32'(inv),         32'd0);
      chk({tag, "_wb_req"},  32'(wb_req),      32'd0);
      chk({tag, "_datasel"}, 32'(datasel),     32'(SOURCE_DMEM));
      chk({tag, "_src_id"},  32'(src_id),      32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_checks = 0;
      n_fail   = 0;
      clear_inputs();
      rst_n = 1'b0;
      #1;
      check_outputs_zero("reset");
      fork
         monitor();
      join_none
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // CPU0 read, no sharers: memory fill, done at cycle 7
      push(mk(4'b0001, 13'h0A5, 2'd0, 4'b0000, 4'd0, 4'b0000, 4'd0, 4'd0, 2'd0, 5'd7));
      issue(0, 1, 0, 0, 13'h0A5);
      run_until_idle(100, 1'b0);

      // CPU2 read, CPU1 holds M: transfer from CPU1 with write-back
      push(mk(4'b0100, 13'h1F0, 2'd0, 4'b0000, 4'd0, 4'b0010, 4'd1, 4'd1, 2'd1, 5'd4));
      set_snoop(1, BLOCK_STATE_M);
      issue(2, 1, 0, 0, 13'h1F0);
      run_until_idle(100, 1'b0);

      // CPU0 write, CPU1 and CPU3 share: memory fill, invalidate both
      push(mk(4'b0001, 13'h123, 2'd1, 4'b1010, 4'd1, 4'b0000, 4'd0, 4'd0, 2'd0, 5'd7));
      set_snoop(1, BLOCK_STATE_S);
      set_snoop(3, BLOCK_STATE_S);
      issue(0, 0, 1, 0, 13'h123);
      run_until_idle(100, 1'b0);

      // CPU3 write, CPU0 holds M: transfer from CPU0 and invalidate it
      push(mk(4'b1000, 13'h0C3, 2'd1, 4'b0001, 4'd1, 4'b0000, 4'd0, 4'd1, 2'd0, 5'd4));
      set_snoop(0, BLOCK_STATE_M);
      issue(3, 0, 1, 0, 13'h0C3);
      run_until_idle(100, 1'b0);

      // CPU1 read: own hit ignored, CPU0 state 11 counts as invalid, CPU3 shares
      push(mk(4'b0010, 13'h777, 2'd0, 4'b0000, 4'd0, 4'b0000, 4'd0, 4'd1, 2'd3, 5'd4));
      set_snoop(0, 2'b11);
      set_snoop(1, BLOCK_STATE_S);
      set_snoop(3, BLOCK_STATE_S);
      issue(1, 1, 0, 0, 13'h777);
      run_until_idle(100, 1'b0);

      // CPU1 upgrade with no other holders: no invalidate pulse
      push(mk(4'b0010, 13'h010, 2'd2, 4'b0000, 4'd0, 4'b0000, 4'd0, 4'd0, 2'd0, 5'd4));
      issue(1, 0, 0, 1, 13'h010);
      run_until_idle(100, 1'b0);

      // CPU2 upgrade, CPU0 and CPU3 share
      push(mk(4'b0100, 13'h0AA, 2'd2, 4'b1001, 4'd1, 4'b0000, 4'd0, 4'd0, 2'd0, 5'd4));
      set_snoop(0, BLOCK_STATE_S);
      set_snoop(3, BLOCK_STATE_S);
      issue(2, 0, 0, 1, 13'h0AA);
      run_until_idle(100, 1'b0);

      // Op priority: rd beats wr and inv; wr beats inv
      push(mk(4'b1000, 13'h0FF, 2'd0, 4'b0000, 4'd0, 4'b0000, 4'd0, 4'd0, 2'd0, 5'd7));
      issue(3, 1, 1, 1, 13'h0FF);
      run_until_idle(100, 1'b0);
      push(mk(4'b0001, 13'h100, 2'd1, 4'b0000, 4'd0, 4'b0000, 4'd0, 4'd0, 2'd0, 5'd7));
      issue(0, 0, 1, 1, 13'h100);
      run_until_idle(100, 1'b0);

      // Request withdrawn during the memory wait still completes
      push(mk(4'b0010, 13'h1AB, 2'd0, 4'b0000, 4'd0, 4'b0000, 4'd0, 4'd0, 2'd0, 5'd7));
      issue(1, 1, 0, 0, 13'h1AB);
      repeat (3) @(negedge clk);
      req_rd[1] = 1'b0;
      run_until_idle(100, 1'b0);

      // All four read from reset: order 0,1,2,3; CPU0 re-requests and waits behind 1..3
      do_reset();
      for (int i = 0; i < N; i++)
         push(mk(4'(1 << i), 13'(13'h200 + i), 2'd0, 4'b0000, 4'd0, 4'b0000, 4'd0, 4'd0, 2'd0, 5'd7));
      push(mk(4'b0001, 13'h200, 2'd0, 4'b0000, 4'd0, 4'b0000, 4'd0, 4'd0, 2'd0, 5'd7));
      for (int i = 0; i < N; i++) issue(i, 1, 0, 0, 13'(13'h200 + i));
      run_until_idle(200, 1'b1);

      // Reset during MEM_WAIT abandons the transaction without a done pulse
      issue(2, 1, 0, 0, 13'h055);
      repeat (3) @(negedge clk);
      chk("pre_reset_busy",  32'(busy),  32'd1);
      chk("pre_reset_grant", 32'(grant), 32'b0100);
      rst_n = 1'b0;
      #1;
      check_outputs_zero("midreset");
      clear_inputs();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("post_reset_busy", 32'(busy), 32'd0);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
